// File: rtl/vram_write_drain.sv
// ---------------------------------------------------------------------------
// vram_write_drain
//
// Consumer end of the VRAM write FIFO. Pops one {address, data} entry at a
// time and shifts it out to the external serial SRAM as a WRITE frame
// (SPI mode 0, MSB first):
//
//   [47:40] command 0x02
//   [39:16] byte address = zero-extended {fifo_read_address, 1'b0}
//   [15:0]  data (DATA_WIDTH bits)
//
// The SRAM pins are shared with the display reader, so every frame is
// bracketed by a bus_request/bus_grant handshake. The grant is only looked
// at while requesting; once a frame starts it always runs to completion.
//
// Optional build macro:
//   VRAM_DRAIN_BURST_EN - after a frame, go straight back to LATCH (keeping
//                         bus_request high) while the FIFO has entries and
//                         fewer than BURST_MAX frames went out in this grant.
//                         Without it every frame goes back through IDLE/REQ.
//
// Parameters:
//   DATA_WIDTH     FIFO data width and length of the SPI data phase
//   ADDRESS_WIDTH  FIFO word-address width (must be <= 23)
//   BURST_MAX      frames per grant, only meaningful with the burst macro
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fifo_empty            FIFO has no entries
//   fifo_read_address     head entry word address (combinational)
//   fifo_read_data        head entry data (combinational)
//   fifo_read_request     one-cycle pop strobe
//   bus_request/bus_grant SRAM pin arbitration
//   sram_cs_n/sck/mosi    serial SRAM pins (idle: cs_n=1, sck=0, mosi=0)
//   busy                  controller is not idle
//   writes_done           completed-frame counter, wraps at 16 bits
//   underrun_error        sticky: a pop was attempted on an empty FIFO
//
// All outputs are registered; they are loaded from the next-state values so
// that each output already reflects the state it belongs to.
// ---------------------------------------------------------------------------
module vram_write_drain #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16,
   parameter int BURST_MAX     = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fifo_empty,
   input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
   input  logic [DATA_WIDTH-1:0]    fifo_read_data,
   output logic                     fifo_read_request,
   output logic                     bus_request,
   input  logic                     bus_grant,
   output logic                     sram_cs_n,
   output logic                     sram_sck,
   output logic                     sram_mosi,
   output logic                     busy,
   output logic [15:0]              writes_done,
   output logic                     underrun_error
);

   localparam int               FRAME_W   = 32 + DATA_WIDTH;
   localparam int               CNT_W     = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
   localparam logic [7:0]       CMD_WRITE = 8'h02;
   localparam int               BURST_W   = $clog2(BURST_MAX + 1);

   // Frames allowed per grant. Without bursting this is 1, which makes the
   // DONE-state continue test below always fail and the frame return to IDLE.
`ifdef VRAM_DRAIN_BURST_EN
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);
`else
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LATCH,
      SHIFT,
      DONE
   } state_t;

   state_t               state, state_n;
   logic [FRAME_W-1:0]   shreg, shreg_n;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
   logic                 phase, phase_n;
   logic [BURST_W-1:0]   burst_cnt, burst_cnt_n;
   logic                 cs_n_n, sck_n, mosi_n, pop_n, underrun_n;
   logic                 frame_end;
   logic [23:0]          byte_addr;
   logic [FRAME_W-1:0]   frame;

   // Word address -> byte address, zero-extended to the 24-bit SRAM field.
   always_comb begin
      byte_addr = '0;
      byte_addr[ADDRESS_WIDTH:0] = {fifo_read_address, 1'b0};
   end

   assign frame = {CMD_WRITE, byte_addr, fifo_read_data};

   // Last clock of the last bit: the frame is complete on this edge.
   assign frame_end = (state == SHIFT) && phase && (bit_cnt == LAST_BIT);

   // ------------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      bit_cnt_n   = bit_cnt;
      phase_n     = phase;
      burst_cnt_n = burst_cnt;
      cs_n_n      = sram_cs_n;
      sck_n       = sram_sck;
      mosi_n      = sram_mosi;
      pop_n       = 1'b0;
      underrun_n  = underrun_error;

      unique case (state)
         IDLE: begin
            burst_cnt_n = '0;
            if (!fifo_empty) state_n = REQ;
         end

         // The pop strobe is registered, so it has to be decided on the
         // edge into LATCH from the FIFO state seen here. This block is the
         // only popper, so an empty FIFO at this point is a genuine underrun.
         REQ: begin
            if (bus_grant) begin
               state_n = LATCH;
               if (fifo_empty) underrun_n = 1'b1;
               else            pop_n      = 1'b1;
            end
         end

         // The head entry is still presented during the pop cycle, so it is
         // captured here. No pop means the entry was missing: abandon.
         LATCH: begin
            if (!fifo_read_request) begin
               state_n = IDLE;
            end else begin
               state_n   = SHIFT;
               shreg_n   = frame;
               bit_cnt_n = '0;
               phase_n   = 1'b0;
               cs_n_n    = 1'b0;
               sck_n     = 1'b0;
               mosi_n    = frame[FRAME_W-1];
            end
         end

         // Two clocks per bit: sck low with mosi set up, then sck high.
         SHIFT: begin
            if (!phase) begin
               phase_n = 1'b1;
               sck_n   = 1'b1;
            end else begin
               phase_n = 1'b0;
               sck_n   = 1'b0;
               if (bit_cnt == LAST_BIT) begin
                  state_n     = DONE;
                  cs_n_n      = 1'b1;
                  mosi_n      = 1'b0;
                  burst_cnt_n = burst_cnt + BURST_W'(1);
               end else begin
                  shreg_n   = {shreg[FRAME_W-2:0], 1'b0};
                  bit_cnt_n = bit_cnt + CNT_W'(1);
                  mosi_n    = shreg[FRAME_W-2];
               end
            end
         end

         // Continuing a burst re-enters LATCH directly, so cs_n stays high
         // through DONE and LATCH between frames.
         DONE: begin
            if (!fifo_empty && (burst_cnt < BURST_LIMIT)) begin
               state_n = LATCH;
               pop_n   = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         shreg             <= '0;
         bit_cnt           <= '0;
         phase             <= 1'b0;
         burst_cnt         <= '0;
         sram_cs_n         <= 1'b1;
         sram_sck          <= 1'b0;
         sram_mosi         <= 1'b0;
         fifo_read_request <= 1'b0;
         bus_request       <= 1'b0;
         busy              <= 1'b0;
         underrun_error    <= 1'b0;
      end else begin
         state             <= state_n;
         shreg             <= shreg_n;
         bit_cnt           <= bit_cnt_n;
         phase             <= phase_n;
         burst_cnt         <= burst_cnt_n;
         sram_cs_n         <= cs_n_n;
         sram_sck          <= sck_n;
         sram_mosi         <= mosi_n;
         fifo_read_request <= pop_n;
         // The request is held from REQ through DONE, i.e. whenever the
         // controller is out of IDLE; dropping it in IDLE releases the pins.
         bus_request       <= (state_n != IDLE);
         busy              <= (state_n != IDLE);
         underrun_error    <= underrun_n;
      end
   end

   // Completed-frame counter; visible in the DONE cycle, wraps naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       writes_done <= '0;
      else if (frame_end) writes_done <= writes_done + 16'd1;
   end

endmodule

// File: tb/tb_vram_write_drain.sv
// ---------------------------------------------------------------------------
// Bench for vram_write_drain. A small FIFO model feeds the DUT; each pushed
// entry queues its hand-computed 48-bit frame. A monitor decodes the SPI pins
// on the falling clock edge and compares every closed frame and the
// writes_done count against the queue.
// ---------------------------------------------------------------------------
module tb_vram_write_drain;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fifo_empty, fifo_read_request, bus_request, bus_grant;
   logic        sram_cs_n, sram_sck, sram_mosi, busy, underrun_error;
   logic [15:0] fifo_read_address, fifo_read_data, writes_done;

   always #5 clk = ~clk;

   // FIFO model
   logic [15:0] fa [16];
   logic [15:0] fd [16];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        force_empty = 1'b0;

   assign fifo_empty        = (wr_ptr == rd_ptr) || force_empty;
   assign fifo_read_address = fa[rd_ptr[3:0]];
   assign fifo_read_data    = fd[rd_ptr[3:0]];

   always @(posedge clk) if (fifo_read_request) rd_ptr <= rd_ptr + 1;

   vram_write_drain dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .fifo_empty        (fifo_empty),
      .fifo_read_address (fifo_read_address),
      .fifo_read_data    (fifo_read_data),
      .fifo_read_request (fifo_read_request),
      .bus_request       (bus_request),
      .bus_grant         (bus_grant),
      .sram_cs_n         (sram_cs_n),
      .sram_sck          (sram_sck),
      .sram_mosi         (sram_mosi),
      .busy              (busy),
      .writes_done       (writes_done),
      .underrun_error    (underrun_error)
   );

   int          checks = 0;
   int          errors = 0;
   logic [47:0] exp_q [$];
   logic [15:0] exp_wd = '0;
   logic        abort_pending = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] d, input logic [47:0] f);
      fa[wr_ptr[3:0]] = a;
      fd[wr_ptr[3:0]] = d;
      exp_q.push_back(f);
      wr_ptr = wr_ptr + 1;
   endtask

   // Monitor / scoreboard
   logic [47:0] rx = '0;
   int          nb = 0;
   int          pop_cnt = 0;
   int          breq_rises = 0;
   logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_breq = 1'b0;

   always @(negedge clk) begin
      if (fifo_read_request) pop_cnt++;
      if (bus_request && !prev_breq) breq_rises++;
      if (!sram_cs_n && sram_sck && !prev_sck) begin
         rx = {rx[46:0], sram_mosi};
         nb++;
      end
      if (sram_cs_n && !prev_cs) begin
         if (abort_pending) begin
            chk("abort_partial", 64'(nb < 48), 64'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            abort_pending = 1'b0;
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected actual=%0h expected=none", rx);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            chk("frame_bits", 64'(nb), 64'd48);
            chk("frame_data", 64'(rx), 64'(e));
            exp_wd = exp_wd + 16'd1;
            chk("writes_done", 64'(writes_done), 64'(exp_wd));
         end
         nb = 0;
      end
      prev_sck  = sram_sck;
      prev_cs   = sram_cs_n;
      prev_breq = bus_request;
   end

   task automatic wait_cs(input logic v, input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (sram_cs_n !== v && n < 300);
      chk(nm, 64'(sram_cs_n), 64'(v));
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end
      while ((exp_q.size() != 0 || busy || wr_ptr != rd_ptr) && n < 3000);
      chk(nm, 64'(exp_q.size() == 0 && !busy && wr_ptr == rd_ptr), 64'd1);
   endtask

   initial begin
      int p0, r0, low, n;
      bus_grant = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      // Reset state
      chk("rst_cs_n",     64'(sram_cs_n), 64'd1);
      chk("rst_sck",      64'(sram_sck), 64'd0);
      chk("rst_breq",     64'(bus_request), 64'd0);
      chk("rst_wd",       64'(writes_done), 64'd0);
      chk("rst_underrun", 64'(underrun_error), 64'd0);
      chk("rst_busy",     64'(busy), 64'd0);

      // Single entry, grant tied high
      bus_grant = 1'b1;
      p0 = pop_cnt;
      push(16'h1234, 16'hBEEF, 48'h02_002468_BEEF);
      wait_cs(1'b0, "single_cs_low");
      wait_cs(1'b1, "single_cs_high");
      chk("single_busy_done", 64'(busy), 64'd1);
      @(negedge clk);
      chk("single_busy_fall", 64'(busy), 64'd0);
      chk("single_pop_once",  64'(pop_cnt - p0), 64'd1);
      wait_drain("single_drain");

      // Grant withheld for 20 cycles, then dropped mid-frame
      bus_grant = 1'b0;
      p0 = pop_cnt;
      push(16'h0001, 16'h5A5A, 48'h02_000002_5A5A);
      repeat (20) @(negedge clk);
      chk("wait_breq",  64'(bus_request), 64'd1);
      chk("wait_cs_n",  64'(sram_cs_n), 64'd1);
      chk("wait_nopop", 64'(pop_cnt - p0), 64'd0);
      bus_grant = 1'b1;
      @(negedge clk);
      chk("grant_pop",   64'(fifo_read_request), 64'd1);
      chk("grant_cs_hi", 64'(sram_cs_n), 64'd1);
      @(negedge clk);
      chk("grant_cs_lo", 64'(sram_cs_n), 64'd0);
      low = 1;
      n = 0;
      while (!sram_cs_n && n < 300) begin
         @(negedge clk);
         n++;
         if (nb >= 10) bus_grant = 1'b0;
         if (!sram_cs_n) low++;
      end
      chk("cs_low_cycles", 64'(low), 64'd96);
      wait_drain("grant_drain");

      // Three entries back to back
      bus_grant = 1'b1;
      r0 = breq_rises;
      push(16'h0000, 16'h0000, 48'h02_000000_0000);
      push(16'hFFFF, 16'hFFFF, 48'h02_01FFFE_FFFF);
      push(16'h8001, 16'h1234, 48'h02_010002_1234);
      wait_drain("three_drain");
`ifdef VRAM_DRAIN_BURST_EN
      chk("three_breq_rises", 64'(breq_rises - r0), 64'd1);
`else
      chk("three_breq_rises", 64'(breq_rises - r0), 64'd3);
`endif

      // Six entries: burst splits 4 + 2, otherwise one grant per frame
      r0 = breq_rises;
      push(16'h0010, 16'h0001, 48'h02_000020_0001);
      push(16'h0011, 16'h0002, 48'h02_000022_0002);
      push(16'h0012, 16'h0004, 48'h02_000024_0004);
      push(16'h0013, 16'h0008, 48'h02_000026_0008);
      push(16'h0014, 16'h0010, 48'h02_000028_0010);
      push(16'h0015, 16'h0020, 48'h02_00002A_0020);
      wait_drain("six_drain");
`ifdef VRAM_DRAIN_BURST_EN
      chk("six_breq_rises", 64'(breq_rises - r0), 64'd2);
`else
      chk("six_breq_rises", 64'(breq_rises - r0), 64'd6);
`endif
      chk("wd_after_six", 64'(writes_done), 64'd11);

      // Reset around bit 20; the popped entry is lost, the next one is clean
      push(16'h00AA, 16'hC3C3, 48'h02_000154_C3C3);
      push(16'h00AB, 16'h3C3C, 48'h02_000156_3C3C);
      n = 0;
      while (nb < 20 && n < 2000) begin @(negedge clk); n++; end
      chk("reach_bit20", 64'(nb >= 20), 64'd1);
      abort_pending = 1'b1;
      #2;
      reset_n = 1'b0;
      exp_wd  = '0;
      #1;
      chk("arst_cs_n", 64'(sram_cs_n), 64'd1);
      chk("arst_sck",  64'(sram_sck), 64'd0);
      chk("arst_breq", 64'(bus_request), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_wd",   64'(writes_done), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_drain("after_reset_drain");

      // writes_done wrap
      @(negedge clk);
      force dut.writes_done = 16'hFFFF;
      @(negedge clk);
      release dut.writes_done;
      exp_wd = 16'hFFFF;
      @(negedge clk);
      chk("wd_preset", 64'(writes_done), 64'hFFFF);
      push(16'h0002, 16'h0003, 48'h02_000004_0003);
      wait_drain("wrap_drain");
      chk("wd_wrapped", 64'(writes_done), 64'd0);

      // Underrun: FIFO appears empty when LATCH is entered
      bus_grant = 1'b0;
      push(16'h0003, 16'h0005, 48'h02_000006_0005);
      n = 0;
      while (!bus_request && n < 20) begin @(negedge clk); n++; end
      p0 = pop_cnt;
      force_empty = 1'b1;
      @(negedge clk);
      bus_grant = 1'b1;
      @(negedge clk);
      chk("ur_nopop", 64'(fifo_read_request), 64'd0);
      @(negedge clk);
      chk("ur_flag", 64'(underrun_error), 64'd1);
      chk("ur_idle", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("ur_nopop_total", 64'(pop_cnt - p0), 64'd0);
      force_empty = 1'b0;
      wait_drain("ur_drain");
      chk("ur_sticky", 64'(underrun_error), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("ur_cleared", 64'(underrun_error), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
